// File: rtl/asip_pkg.sv
// Shared encodings for the min/max/average unit.
//   - Operation select codes driven on the unit's op port.
//   - FSM state type used by minmaxavg_unit.
// No ports; import with "import asip_pkg::*;".
package asip_pkg;

  localparam logic [1:0] OP_MAX  = 2'b00;
  localparam logic [1:0] OP_MIN  = 2'b01;
  localparam logic [1:0] OP_AVG  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCollect = 2'b01,
    StFinish  = 2'b10
  } mma_state_e;

endpackage

// File: rtl/minmaxavg_unit.sv
// Collects 2^N_LOG2 unsigned 8-bit samples and reports their maximum, minimum or average.
//
// Parameters:
//   N_LOG2      log2 of samples per operation (1..6)
// Ports:
//   CLK         clock, rising edge
//   RESET       asynchronous active-low reset
//   start       begin an operation (sampled only while idle)
//   op[1:0]     operation select latched at start (MAX/MIN/AVG/reserved)
//   data_in     unsigned sample
//   data_valid  sample qualifier while collecting
//   result      last computed result, registered, held between operations
//   result_load one-cycle pulse while result carries a new value
//   busy        high while collecting or finishing
//   done        one-cycle pulse coincident with result_load
// Build option:
//   MINMAXAVG_ROUND_EN  defined: AVG rounds half up; undefined: AVG truncates.
module minmaxavg_unit
  import asip_pkg::*;
#(
  parameter int unsigned N_LOG2 = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] result,
  output logic       result_load,
  output logic       busy,
  output logic       done
);

  localparam int unsigned SumW = 9 + N_LOG2;
  localparam int unsigned CntW = N_LOG2 + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'((2 ** N_LOG2) - 1);

  mma_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      max_q, max_d;
  logic [7:0]      min_q, min_d;
  logic [SumW-1:0] sum_q, sum_d;
  logic [7:0]      result_q, result_d;

  // Trackers including the sample on data_in, so the final result can be
  // registered on the same edge that accepts the last sample.
  logic [7:0]      max_acc, min_acc, avg_val;
  logic [SumW-1:0] sum_acc, avg_full;
  logic [7:0]      sel_val;

  always_comb begin
    max_acc = (data_in > max_q) ? data_in : max_q;
    min_acc = (data_in < min_q) ? data_in : min_q;
    sum_acc = sum_q + SumW'(data_in);
`ifdef MINMAXAVG_ROUND_EN
    // Largest sum plus half still fits in SumW bits.
    avg_full = (sum_acc + (SumW'(1) << (N_LOG2 - 1))) >> N_LOG2;
`else
    avg_full = sum_acc >> N_LOG2;
`endif
    avg_val = avg_full[7:0];
    unique case (op_q)
      OP_MAX:  sel_val = max_acc;
      OP_MIN:  sel_val = min_acc;
      OP_AVG:  sel_val = avg_val;
      default: sel_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    min_d    = min_q;
    sum_d    = sum_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          max_d = 8'h00;
          min_d = 8'hFF;
          sum_d = '0;
          if (op == OP_RSVD) begin
            result_d = 8'h00;
            state_d  = StFinish;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (data_valid) begin
          max_d = max_acc;
          min_d = min_acc;
          sum_d = sum_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            result_d = sel_val;
            state_d  = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      op_q     <= OP_MAX;
      cnt_q    <= '0;
      max_q    <= 8'h00;
      min_q    <= 8'hFF;
      sum_q    <= '0;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      min_q    <= min_d;
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  // Result is already registered when FINISH is entered, so the load pulse
  // lines up with a stable value.
  assign result      = result_q;
  assign result_load = (state_q == StFinish);
  assign done        = (state_q == StFinish);
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/minmaxavg_unit.md
MINMAXAVG_UNIT -- requirements
Module: minmaxavg_unit

Interface
REQ-001 Parameter N_LOG2, default 3, SHALL set samples per operation to 2^N_LOG2; legal range 1..6.
REQ-002 CLK  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be the reset, asynchronous, active-low.
REQ-004 start  input  1  SHALL request a new operation; sampled only in IDLE.
REQ-005 op  input  2  SHALL select the operation at start: 00 MAX, 01 MIN, 10 AVG, 11 reserved.
REQ-006 data_in  input  8  SHALL carry an unsigned sample.
REQ-007 data_valid  input  1  SHALL qualify data_in; a sample is accepted when data_valid=1 in COLLECT.
REQ-008 result  output  8  SHALL hold the last computed result, registered.
REQ-009 result_load  output  1  SHALL pulse one cycle with a new result, for direct connection to the downstream 8-bit register load enable.
REQ-010 busy  output  1  SHALL be 1 in COLLECT and FINISH.
REQ-011 done  output  1  SHALL pulse one cycle, coincident with result_load.

Function
REQ-012 FSM states SHALL be IDLE, COLLECT, FINISH.
REQ-013 IDLE->COLLECT on start=1; op latched; count cleared; MAX tracker=0x00, MIN tracker=0xFF, sum=0.
REQ-014 start with op=11 SHALL go IDLE->FINISH directly, producing result=0x00.
REQ-015 In COLLECT each accepted sample SHALL update max, min and sum in the same cycle and increment count.
REQ-016 data_valid=0 in COLLECT SHALL hold all state; no timeout.
REQ-017 On acceptance of sample 2^N_LOG2, state SHALL go to FINISH.
REQ-018 In FINISH the selected value SHALL be written to result, result_load=done=1 for exactly one cycle, then IDLE.
REQ-019 result_load SHALL rise the cycle after the last sample is accepted (latency 1).
REQ-020 start in COLLECT/FINISH SHALL be ignored; start in FINISH does not chain.
REQ-021 Sum register SHALL be 9+N_LOG2 bits unsigned; no overflow possible.
REQ-022 AVG SHALL be sum >> N_LOG2 (truncating) unless REQ-026 applies.
REQ-023 Equal samples: MAX/MIN SHALL return that value; ties have no side effect.
REQ-024 result SHALL hold its value between operations.

Reset
REQ-025 RESET=0 SHALL immediately force IDLE, result=0x00, result_load=0, done=0, busy=0, count=0, sum=0, max=0x00, min=0xFF, aborting any operation without a result_load pulse.

Configuration
REQ-026 Macro MINMAXAVG_ROUND_EN defined: AVG SHALL be (sum + 2^(N_LOG2-1)) >> N_LOG2 (round half up); undefined: truncation per REQ-022; MAX/MIN unaffected.

Structure
REQ-027 Op encodings (OP_MAX, OP_MIN, OP_AVG, OP_RSVD) and FSM state encodings SHALL live in shared package asip_pkg.
REQ-028 The FSM and datapath SHALL reside in one module; no sub-module.

Verification (N_LOG2=3)
REQ-029 op=00, samples 3,250,7,0,128,9,250,1 -> result=250, result_load one pulse the cycle after sample 8.
REQ-030 op=01, same samples with data_valid gaps of 2 cycles -> result=0, busy held through gaps.
REQ-031 op=10, samples 1,2,2,2,2,2,2,2 (sum 15) -> result=1 without macro, 2 with MINMAXAVG_ROUND_EN; all 0xFF -> 255 both builds.
REQ-032 op=11 start -> FINISH next cycle, result=0x00, done pulse, no samples consumed.
REQ-033 RESET low after 4 samples -> result=0x00, busy=0 immediately, no result_load; new op=00 afterwards yields correct max.
REQ-034 start held high through an operation -> exactly one result_load, re-start only after return to IDLE.
